// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver. Each channel independently runs OFF, ON, BLINK
// (programmable half-period) or PWM (programmable duty). Configuration arrives
// through a single-cycle write port; every write restarts that channel's phase.
// led_out and wrap_pulse are registered and aligned with each other.
module led_blink_ctrl #(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 11_999_999,
  parameter int PWM_W          = 8,
  parameter int ACTIVE_LOW     = 0,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] led_out,
  output logic [NUM_CH-1:0] wrap_pulse
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  localparam logic [NUM_CH-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

  // Per-channel LED level and wrap indication, before the output register.
  logic [NUM_CH-1:0] led_nxt;
  logic [NUM_CH-1:0] wrap_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_t             mode,      mode_nxt;
    logic [CNT_W-1:0]  period,    period_nxt;
    logic [PWM_W-1:0]  duty,      duty_nxt;
    logic [CNT_W-1:0]  bcnt,      bcnt_nxt;
    logic [PWM_W-1:0]  pcnt,      pcnt_nxt;
    logic              led_state, led_state_nxt;
    logic              evt_p0,    evt_nxt;
    logic              wr_hit;

    // A write addressed to an out-of-range channel never matches any index.
    assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

    // Next-state: a write wins over any toggle/wrap due on the same edge.
    always_comb begin
      mode_nxt      = mode;
      period_nxt    = period;
      duty_nxt      = duty;
      bcnt_nxt      = bcnt;
      pcnt_nxt      = pcnt;
      led_state_nxt = led_state;
      evt_nxt       = 1'b0;
      if (wr_hit) begin
        mode_nxt      = mode_t'(cfg_mode);
        period_nxt    = cfg_period;
        duty_nxt      = cfg_duty;
        bcnt_nxt      = '0;
        pcnt_nxt      = '0;
        led_state_nxt = 1'b0;
      end else begin
        case (mode)
          MODE_BLINK: begin
            // Compare before increment so the counter can never pass period.
            if (bcnt == period) begin
              bcnt_nxt      = '0;
              led_state_nxt = ~led_state;
              evt_nxt       = 1'b1;
            end else begin
              bcnt_nxt = bcnt + 1'b1;
            end
          end
          MODE_PWM: pcnt_nxt = pcnt + 1'b1;
          default: begin
            bcnt_nxt = '0;
            pcnt_nxt = '0;
          end
        endcase
      end
    end

    // Channel state register; reset restores the power-up configuration.
    always_ff @(posedge clk) begin
      if (rst) begin
        mode      <= MODE_OFF;
        period    <= CNT_W'(DEFAULT_PERIOD);
        duty      <= '0;
        bcnt      <= '0;
        pcnt      <= '0;
        led_state <= 1'b0;
        evt_p0    <= 1'b0;
      end else begin
        mode      <= mode_nxt;
        period    <= period_nxt;
        duty      <= duty_nxt;
        bcnt      <= bcnt_nxt;
        pcnt      <= pcnt_nxt;
        led_state <= led_state_nxt;
        evt_p0    <= evt_nxt;
      end
    end

    // Stage p0 -> output: derive the LED level from the registered state.
    // The BLINK toggle event is delayed one stage so the pulse lands on the
    // same cycle as the led_out edge it announces.
    assign led_nxt[i]  = (mode == MODE_ON) ||
                         ((mode == MODE_BLINK) && led_state) ||
                         ((mode == MODE_PWM) && (pcnt < duty));
    assign wrap_nxt[i] = (mode == MODE_PWM) ? (pcnt == {PWM_W{1'b1}}) :
                         ((mode == MODE_BLINK) && evt_p0);
  end

  // Output register with optional polarity inversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out    <= POL;
      wrap_pulse <= '0;
    end else begin
      led_out    <= led_nxt ^ POL;
      wrap_pulse <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: a stimulus process applies directed vectors and
// queues the expected outputs; a monitor pops and compares every cycle.
// Two instances share the inputs: one active-high, one active-low.
module tb_led_blink_ctrl;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 24;
  localparam int PWM_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [PWM_W-1:0] cfg_duty = '0;
  logic [2:0]       led_out, wrap_pulse, led_al, wrap_al;

  always #5 clk = ~clk;

  led_blink_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .led_out(led_out), .wrap_pulse(wrap_pulse)
  );

  led_blink_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .led_out(led_al), .wrap_pulse(wrap_al)
  );

  typedef struct {
    int         tag;
    logic [2:0] led;
    logic [2:0] wrap;
    logic [2:0] mask;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Hand formulas for a blink channel written at edge W; j counts outputs after W.
  function automatic logic bl(int j, int p);
    return (j >= 1) ? logic'(((j - 1) / (p + 1)) % 2) : 1'b0;
  endfunction

  function automatic logic bw(int j, int p);
    return (j > 1) && (((j - 1) % (p + 1)) == 0);
  endfunction

  // Consume one clock edge and queue the outputs expected just after it.
  task automatic tick(input int tag, input logic [2:0] led, input logic [2:0] wrap,
                      input logic [2:0] mask);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag  = tag;
    e.led  = led;
    e.wrap = wrap;
    e.mask = mask;
    sb.push_back(e);
    cfg_we = 1'b0;
  endtask

  // Present a configuration write for the next edge.
  task automatic wr(input int ch, input int mode, input int period, input int duty);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CNT_W'(period);
    cfg_duty   = PWM_W'(duty);
  endtask

  task automatic pulse_reset(input int tag);
    rst = 1'b1;
    tick(tag, 3'b000, 3'b000, 3'b111);
    rst = 1'b0;
    tick(tag, 3'b000, 3'b000, 3'b111);
  endtask

  // Monitor: compare whatever the DUTs present against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.mask != 3'b000) begin
        vectors++;
        if (((led_out    & mon_e.mask) != (mon_e.led  & mon_e.mask)) ||
            ((wrap_pulse & mon_e.mask) != (mon_e.wrap & mon_e.mask)) ||
            ((led_al     & mon_e.mask) != (~mon_e.led & mon_e.mask)) ||
            ((wrap_al    & mon_e.mask) != (mon_e.wrap & mon_e.mask))) begin
          miscompares++;
          $display("FAIL t%0d @%0t led_out=%b wrap=%b led_al=%b wrap_al=%b required led=%b wrap=%b led_al=%b mask=%b",
                   mon_e.tag, $time, led_out, wrap_pulse, led_al, wrap_al,
                   mon_e.led, mon_e.wrap, ~mon_e.led, mon_e.mask);
        end
      end
    end
  end

  initial begin
    logic [PWM_W-1:0] pcv;

    // t1: reset state, then 100 idle cycles.
    tick(1, 3'b000, 3'b000, 3'b111);
    tick(1, 3'b000, 3'b000, 3'b111);
    rst = 1'b0;
    repeat (100) tick(1, 3'b000, 3'b000, 3'b111);

    // t2: ch0 BLINK period=3 -> 0000111100001111...
    wr(0, 2, 3, 0);
    tick(2, 3'b000, 3'b000, 3'b111);
    for (int j = 1; j <= 15; j++)
      tick(2, {2'b00, bl(j, 3)}, {2'b00, bw(j, 3)}, 3'b111);

    // t6: reset while led_out[0]=1 and counter=2, then ch0 stays dark.
    rst = 1'b1;
    tick(6, 3'b000, 3'b000, 3'b111);
    rst = 1'b0;
    repeat (10) tick(6, 3'b000, 3'b000, 3'b111);

    // t3: ch1 PWM duty=64 over 4 windows; last edge rewrites duty=0.
    wr(1, 3, 0, 64);
    tick(3, 3'b000, 3'b000, 3'b111);
    for (int j = 1; j <= 1025; j++) begin
      if (j == 1025) wr(1, 3, 0, 0);
      pcv = PWM_W'(j - 1);
      tick(3, {1'b0, pcv < 8'd64, 1'b0}, {1'b0, pcv == 8'd255, 1'b0}, 3'b111);
    end

    // t4: duty=0 never lights, wrap still every 256 cycles.
    for (int j = 1; j <= 300; j++) begin
      pcv = PWM_W'(j - 1);
      tick(4, 3'b000, {1'b0, pcv == 8'd255, 1'b0}, 3'b111);
    end
    pulse_reset(4);

    // t5: ch2 BLINK period=5, rewritten to period=2 on its wrap edge.
    wr(2, 2, 5, 0);
    tick(5, 3'b000, 3'b000, 3'b111);
    for (int j = 1; j <= 20; j++) begin
      if (j == 6) wr(2, 2, 2, 0);
      if (j <= 6) tick(5, 3'b000, 3'b000, 3'b111);
      else        tick(5, {bl(j - 6, 2), 2'b00}, {bw(j - 6, 2), 2'b00}, 3'b111);
    end
    pulse_reset(5);

    // t7: ch1 BLINK period=4; invalid-channel write, then ch0 ON.
    wr(1, 2, 4, 0);
    tick(7, 3'b000, 3'b000, 3'b111);
    for (int j = 1; j <= 25; j++) begin
      if (j == 3) wr(3, 1, 7, 9);
      if (j == 7) wr(0, 1, 0, 0);
      tick(7, {1'b0, bl(j, 4), logic'(j >= 8)}, {1'b0, bw(j, 4), 1'b0}, 3'b111);
    end
    pulse_reset(7);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain queued=%0d required=0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Parametrised multi-channel LED driver; successor to the single fixed-rate blinker.
- Each channel runs independently in one of four modes: OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- Sits between the on-chip oscillator clock domain and the LED pads.
- Configured at runtime through a single-cycle write port; no CPU handshake is needed.

Parameters:
- NUM_CH, 3, number of LED channels (1..8).
- CNT_W, 24, width of each blink counter and of cfg_period.
- DEFAULT_PERIOD, 11_999_999, half-period terminal count loaded at reset (1 s at 12 MHz).
- PWM_W, 8, width of the PWM counter and of cfg_duty.
- ACTIVE_LOW, 0, when 1 every led_out bit is inverted at the output register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 PWM.
- cfg_period  in  CNT_W  BLINK terminal count (half-period = cfg_period+1 cycles).
- cfg_duty  in  PWM_W  PWM high-time in counts.
- led_out  out  NUM_CH  registered LED drive, bit i = channel i.
- wrap_pulse  out  NUM_CH  one-cycle pulse per channel at each BLINK toggle / PWM counter wrap.

Behaviour:
- Reset (rst=1 at clk edge): for every channel, mode=OFF, period=DEFAULT_PERIOD, duty=0, blink counter=0, pwm counter=0, led_state=0. Outputs: wrap_pulse=0; led_out=0 (all ones if ACTIVE_LOW=1). Reset overrides cfg_we in the same cycle.
- Config write:
  - cfg_we=1 with cfg_ch<NUM_CH updates mode, period and duty of that channel at the edge.
  - The same edge clears that channel's blink counter, pwm counter and led_state (phase restart).
  - The new mode is reflected on led_out one cycle later.
  - cfg_ch>=NUM_CH: the write is ignored, no state change.
  - Other channels are never disturbed by a write.
- Per-channel logic runs every cycle; no shared prescaler.
- OFF: led_out bit=0 (before polarity); counters held at 0; wrap_pulse=0.
- ON: led_out bit=1; counters held at 0; wrap_pulse=0.
- BLINK:
  - If counter==period: counter<=0, led_state toggles, wrap_pulse asserted for exactly that cycle. Otherwise counter increments by 1.
  - period=0 gives a toggle every cycle with wrap_pulse held high.
  - The counter never exceeds period.
  - If period is lowered below the current count by a write, the counter clears on that write, so no overrun case exists.
- PWM:
  - The pwm counter free-runs 0..2^PWM_W-1 and wraps to 0.
  - wrap_pulse is high in the cycle the registered counter equals 2^PWM_W-1.
  - led bit = (pwm counter < duty), unsigned compare.
  - duty=0 gives constantly 0; duty=2^PWM_W-1 gives high for 255 of 256 cycles (PWM_W=8). Full-on is reached via ON mode.
- Output timing: led_out and wrap_pulse are registered. led_out reflects state with 1-cycle latency; wrap_pulse is aligned with the led_out change it announces.
- Simultaneous events:
  - A write to channel i on the cycle channel i would wrap: the write wins; no toggle and no pulse occur.
  - A wrap on channel j≠i proceeds normally.
- Mid-operation reset: all channels return to their reset state on the next edge regardless of mode or counter value.
- Arithmetic: all counters are unsigned. The blink counter never wraps through 2^CNT_W because it is compared against period first.

Test Plan:
- Reset: after rst deasserts, hold idle 100 cycles -> led_out=000, wrap_pulse=000. Repeat with ACTIVE_LOW=1 -> led_out=111.
- Blink: write ch0 mode=BLINK, period=3 -> led_out[0] toggles every 4 cycles. Sequence 0000111100001111… starts 1 cycle after the write. wrap_pulse[0] is high on each toggle cycle only. Ch1 and ch2 stay 0.
- PWM (PWM_W=8): write ch1 mode=PWM, duty=64 -> exactly 64 high cycles per 256-cycle window, measured over 4 windows. wrap_pulse[1] occurs every 256 cycles. duty=0 -> never high.
- Write/wrap collision: ch2 BLINK period=5; rewrite ch2 with period=2 on the exact cycle its counter equals 5 -> no toggle and no pulse that cycle. Next toggle occurs 3 cycles later.
- Invalid channel and isolation: with NUM_CH=3, write cfg_ch=3 -> no channel changes. Write ch0=ON while ch1 blinks -> ch1 phase is unaffected (toggle times unchanged).
- Reset mid-blink: assert rst for 1 cycle while ch0 blinks with led_out[0]=1 and counter=2 -> next cycle led_out=000, mode OFF. Ch0 stays dark until rewritten.
